// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, class count and classifier state encoding for the inference pipeline.
package nn_pkg;
    localparam int VALUE_W     = 26;
    localparam int FRAC_W      = 18;
    localparam int PIXEL_W     = 10;
    localparam int WEIGHT_W    = 19;
    localparam int NUM_CLASSES = 10;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/signed_max_cmp.sv
// signed_max_cmp: combinational signed maximum of two scored candidates; equal scores go to the lower index.
module signed_max_cmp
    import nn_pkg::*;
#(
    parameter int VALUE_W = nn_pkg::VALUE_W,
    parameter int IDX_W   = 4
) (
    input  logic [VALUE_W-1:0] a,
    input  logic [VALUE_W-1:0] b,
    input  logic [IDX_W-1:0]   a_idx,
    input  logic [IDX_W-1:0]   b_idx,
    output logic [VALUE_W-1:0] max_value,
    output logic [IDX_W-1:0]   max_idx
);
    logic take_b;
    assign take_b    = $signed(b) > $signed(a) || (b == a && b_idx < a_idx);
    assign max_value = take_b ? b : a;
    assign max_idx   = take_b ? b_idx : a_idx;
endmodule

// File: rtl/argmax_classifier.sv
// argmax_classifier: streams NUM_CLASSES signed scores per frame and pulses out the index and value of the largest.
module argmax_classifier
    import nn_pkg::*;
#(
    parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
    parameter int VALUE_W     = nn_pkg::VALUE_W,
    parameter int IDX_W       = 4
) (
    input  logic               clk,
    input  logic               GlobalReset,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [VALUE_W-1:0] in_value,
    output logic               out_valid,
    output logic [IDX_W-1:0]   class_idx,
    output logic [VALUE_W-1:0] max_value,
    output logic               busy
);
    localparam logic [IDX_W:0] LAST = (IDX_W+1)'(NUM_CLASSES - 1);
    state_t state, state_next;
    logic [IDX_W:0] count;
    logic [VALUE_W-1:0] run_max, cmp_value, win_value;
    logic [IDX_W-1:0] run_idx, cmp_idx, win_idx;
    logic xfer, last;
    signed_max_cmp #(.VALUE_W(VALUE_W), .IDX_W(IDX_W)) u_cmp (
        .a        (run_max),
        .b        (in_value),
        .a_idx    (run_idx),
        .b_idx    (count[IDX_W-1:0]),
        .max_value(cmp_value),
        .max_idx  (cmp_idx)
    );
    // clear discards a same-cycle beat, so it is folded into the transfer qualifier
    always_comb begin
        in_ready   = state != DONE;
        busy       = state == ACCUM;
        out_valid  = state == DONE;
        xfer       = in_valid && in_ready && !clear;
        last       = xfer && count == LAST;
        win_value  = state == IDLE ? in_value : cmp_value;
        win_idx    = state == IDLE ? '0 : cmp_idx;
        state_next = (state == DONE || clear) ? IDLE : last ? DONE : xfer ? ACCUM : state;
    end
    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            state     <= IDLE;
            count     <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            class_idx <= '0;
            max_value <= '0;
        end else begin
            state <= state_next;
            if (state == DONE || clear)
                count <= '0;
            else if (xfer) begin
                count   <= count + 1'b1;
                run_max <= win_value;
                run_idx <= win_idx;
            end
            if (last) begin
                class_idx <= win_idx;
                max_value <= win_value;
            end
        end
    end
endmodule

// File: tb/tb_argmax_classifier.sv
// tb_argmax_classifier: random and directed frames checked every cycle against a queue-based argmax model.
module tb_argmax_classifier;
    localparam int N = 10, W = 26, IW = 4;
    logic clk = 1'b0;
    logic GlobalReset, clear, in_valid, in_ready, out_valid, busy;
    logic [W-1:0] in_value, max_value;
    logic [IW-1:0] class_idx;
    int checks = 0, failures = 0, pulses = 0;
    bit started = 1'b0;
    logic [W-1:0] frame[$];
    bit exp_valid = 1'b0;
    logic [IW-1:0] exp_idx = '0;
    logic [W-1:0] exp_max = '0;
    logic [W-1:0] v[N];

    always #5 clk = ~clk;

    argmax_classifier dut (
        .clk(clk), .GlobalReset(GlobalReset), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .in_value(in_value), .out_valid(out_valid),
        .class_idx(class_idx), .max_value(max_value), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void argmax(input logic [W-1:0] q[$], output logic [IW-1:0] idx, output logic [W-1:0] mx);
        idx = '0;
        mx = q[0];
        foreach (q[i]) if ($signed(q[i]) > $signed(mx)) begin
            mx = q[i];
            idx = IW'(i);
        end
    endfunction

    // model: the frame is the list of accepted scores; a full list yields one result cycle
    initial forever begin
        @(posedge clk);
        if (!GlobalReset) begin
            started = 1'b1;
            frame.delete();
            exp_valid = 1'b0;
            exp_idx = '0;
            exp_max = '0;
        end else if (exp_valid) exp_valid = 1'b0;
        else if (clear) frame.delete();
        else if (in_valid) begin
            frame.push_back(in_value);
            if (frame.size() == N) begin
                argmax(frame, exp_idx, exp_max);
                exp_valid = 1'b1;
                frame.delete();
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("out_valid", out_valid, exp_valid);
            chk("in_ready", in_ready, !exp_valid);
            chk("busy", busy, frame.size() > 0);
            chk("class_idx", class_idx, exp_idx);
            chk("max_value", max_value, exp_max);
            if (out_valid) pulses++;
        end
    end

    task automatic send(input logic [W-1:0] val, input int gap);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_value = val;
        for (int t = 0; t < 20 && !in_ready; t++) @(negedge clk);
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < N; i++) send(v[i], i == 0 ? 0 : gap);
    endtask

    task automatic wait_done(input string name, input logic [IW-1:0] idx, input logic [W-1:0] mx);
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_out_valid required=out_valid", name);
        end else begin
            chk({name, "_idx"}, class_idx, idx);
            chk({name, "_max"}, max_value, mx);
            chk({name, "_model_idx"}, exp_idx, idx);
        end
        @(negedge clk);
        chk({name, "_hold"}, class_idx, idx);
    endtask

    initial begin
        int p0;
        GlobalReset = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        in_value = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_class_idx", class_idx, 0);
        chk("rst_max_value", max_value, 0);
        chk("rst_busy", busy, 0);
        GlobalReset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        for (int k = 0; k < N; k++) v[k] = W'(k) << 18;
        send_frame(0);
        wait_done("ascending", 4'd9, 26'h0240000);

        v[0] = 26'h3FC0000; v[1] = 26'h3FE0000; v[2] = 26'h00D0000; v[3] = 26'h00D0000;
        for (int k = 4; k < N; k++) v[k] = '0;
        send_frame(0);
        wait_done("mixed", 4'd2, 26'h00D0000);

        for (int k = 0; k < N; k++) v[k] = 26'h2000000;
        v[7] = 26'h3FFFFFF;
        send_frame(0);
        wait_done("negative", 4'd7, 26'h3FFFFFF);

        for (int k = 0; k < N; k++) v[k] = W'($urandom_range(0, 26'h03FFFFF));
        v[4] = 26'h0400000;
        send_frame(2);
        wait_done("gappy", 4'd4, 26'h0400000);

        for (int k = 0; k < 5; k++) send(k == 3 ? 26'h1FFFFFF : W'($urandom), 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_busy", busy, 0);
        p0 = pulses;
        v[0] = 26'h0100000;
        for (int k = 1; k < N; k++) v[k] = W'($urandom_range(0, 26'h00FFFFF));
        send_frame(0);
        wait_done("after_clear", 4'd0, 26'h0100000);
        repeat (3) @(negedge clk);
        chk("clear_pulses", pulses - p0, 1);

        for (int k = 0; k < 6; k++) send(26'h1FFFFFF, 0);
        GlobalReset = 1'b0;
        @(negedge clk);
        GlobalReset = 1'b1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_class_idx", class_idx, 0);
        chk("midrst_max_value", max_value, 0);
        chk("midrst_busy", busy, 0);
        p0 = pulses;
        for (int k = 0; k < N; k++) v[k] = W'($urandom_range(0, 26'h00FFFFF));
        v[5] = 26'h0500000;
        send_frame(1);
        wait_done("after_rst", 4'd5, 26'h0500000);
        repeat (3) @(negedge clk);
        chk("midrst_pulses", pulses - p0, 1);

        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < N; i++) begin
                logic [W-1:0] r;
                case ($urandom_range(0, 5))
                    0: r = 26'h2000000;
                    1: r = 26'h3FFFFFF;
                    2: r = 26'h1FFFFFF;
                    3: r = W'($urandom_range(0, 3));
                    default: r = W'($urandom);
                endcase
                send(r, $urandom_range(0, 2));
                if ($urandom_range(0, 29) == 0) begin
                    in_valid = 1'b1;
                    in_value = W'($urandom);
                    clear = 1'b1;
                    @(negedge clk);
                    clear = 1'b0;
                    in_valid = 1'b0;
                end
            end
        end
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
